// File: rtl/free_list_if.sv
// Dispatch/retire/recovery port bundle of the physical-register free list.
// The core side drives the master modport; the free list implements the slave.
interface free_list_if #(
    parameter int PHYS_BITS = 6,
    parameter int PTR_BITS  = 6
);
    logic [1:0][4:0]           de_destidx;
    logic [1:0]                haz_nDispatched;
    logic [1:0]                rob_retireEn;
    logic [1:0][PHYS_BITS-1:0] rob_retireTagOld;
    logic                      br_pred_wrong;
    logic [PTR_BITS-1:0]       bs_recov_head;
    logic [1:0][PHYS_BITS-1:0] fl_freeRegs;
    logic [PTR_BITS-1:0]       fl_head;
    logic [PTR_BITS-1:0]       fl_numFree;

    modport master (
        output de_destidx, haz_nDispatched, rob_retireEn, rob_retireTagOld,
               br_pred_wrong, bs_recov_head,
        input  fl_freeRegs, fl_head, fl_numFree
    );

    modport slave (
        input  de_destidx, haz_nDispatched, rob_retireEn, rob_retireTagOld,
               br_pred_wrong, bs_recov_head,
        output fl_freeRegs, fl_head, fl_numFree
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: 2-wide allocate at dispatch,
// 2-wide compacted reclaim at retire, head restore on branch mispredict.
module free_list #(
    parameter int FL_SIZE   = 32,
    parameter int PHYS_BITS = 6,
    parameter int PTR_BITS  = 6
) (
    input logic       clk,
    input logic       reset,
    free_list_if.slave fl
);
    localparam int IDX_BITS = PTR_BITS - 1;
    localparam int NUM_ARCH = 32;

    typedef logic [PTR_BITS-1:0]  ptr_t;
    typedef logic [PTR_BITS:0]    wide_ptr_t;
    typedef logic [PHYS_BITS-1:0] tag_t;

    tag_t       entries_q [FL_SIZE];
    tag_t       entries_d [FL_SIZE];
    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    ptr_t       head_p1;
    ptr_t       wr_ptr;
    ptr_t       num_free;
    logic [1:0] alloc;
    logic [1:0] n_pop;
    logic [1:0] n_push;

    // Slot 1 reads one entry further only when slot 0 actually takes a tag.
    always_comb begin
        alloc[0] = (fl.haz_nDispatched > 2'd0) && (fl.de_destidx[0] != 5'd31);
        alloc[1] = (fl.haz_nDispatched > 2'd1) && (fl.de_destidx[1] != 5'd31);
        n_pop    = {1'b0, alloc[0]} + {1'b0, alloc[1]};
        head_p1  = head_q + ptr_t'(1);
        fl.fl_freeRegs[0] = entries_q[head_q[IDX_BITS-1:0]];
        fl.fl_freeRegs[1] = alloc[0] ? entries_q[head_p1[IDX_BITS-1:0]]
                                     : entries_q[head_q[IDX_BITS-1:0]];
    end

    always_comb begin
        // NOTE: blocking assignments here let wr_ptr advance between the two
        // retire slots, which is what compacts a lone slot-1 tag onto tail.
        entries_d = entries_q;
        wr_ptr    = tail_q;
        n_push    = 2'd0;
        if (fl.rob_retireEn[0]) begin
            entries_d[wr_ptr[IDX_BITS-1:0]] = fl.rob_retireTagOld[0];
            wr_ptr = wr_ptr + ptr_t'(1);
            n_push = n_push + 2'd1;
        end
        if (fl.rob_retireEn[1]) begin
            entries_d[wr_ptr[IDX_BITS-1:0]] = fl.rob_retireTagOld[1];
            wr_ptr = wr_ptr + ptr_t'(1);
            n_push = n_push + 2'd1;
        end
        tail_d = wr_ptr;
        head_d = fl.br_pred_wrong ? fl.bs_recov_head : head_q + ptr_t'(n_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= ptr_t'(FL_SIZE);
            // NOTE: the tag array is reset on purpose: its reset contents are
            // the initial pool of free tags, not scratch data.
            for (int i = 0; i < FL_SIZE; i++) begin
                entries_q[i] <= tag_t'(NUM_ARCH + i);
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

    assign num_free      = tail_q - head_q;
    assign fl.fl_numFree = num_free;
    assign fl.fl_head    = head_q;

    // Recovery point offset from (head - FL_SIZE) must not pass the tail.
    wide_ptr_t recov_rel;
    wide_ptr_t recov_span;
    assign recov_rel  = {1'b0, ptr_t'(fl.bs_recov_head - head_q + ptr_t'(FL_SIZE))};
    assign recov_span = {1'b0, num_free} + wide_ptr_t'(FL_SIZE);

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !fl.br_pred_wrong |-> (ptr_t'(n_pop) <= num_free));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (num_free + ptr_t'(n_push)) <= ptr_t'(FL_SIZE));
    a_recov_range: assert property (@(posedge clk) disable iff (!reset)
        fl.br_pred_wrong |-> (recov_rel <= recov_span));
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic
// compared against an unbounded tag-log model with absolute head/tail counts.
module tb_free_list;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    free_list_if #(.PHYS_BITS(6), .PTR_BITS(6)) fl ();
    free_list #(.FL_SIZE(32), .PHYS_BITS(6), .PTR_BITS(6)) dut (
        .clk  (clk),
        .reset(reset),
        .fl   (fl)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_log[k] is the tag at absolute FIFO position k; head/tail never wrap.
    int m_log[$];
    int m_head;
    int m_tail;

    function automatic bit m_alloc(int s);
        return (int'(fl.haz_nDispatched) > s) && (fl.de_destidx[s] != 5'd31);
    endfunction

    function automatic int m_at(int k);
        if (k < m_log.size()) return m_log[k];
        return -1;
    endfunction

    function automatic int m_free(int s);
        if (s == 1 && m_alloc(0)) return m_at(m_head + 1);
        return m_at(m_head);
    endfunction

    function automatic int m_num();
        return m_tail - m_head;
    endfunction

    function automatic int m_hptr();
        return m_head % 64;
    endfunction

    task automatic m_reset();
        m_log.delete();
        for (int i = 0; i < 32; i++) m_log.push_back(32 + i);
        m_head = 0;
        m_tail = 32;
    endtask

    task automatic m_step();
        int n_pop;
        int d;
        n_pop = int'(m_alloc(0)) + int'(m_alloc(1));
        d = (m_tail - int'(fl.bs_recov_head)) % 64;
        if (d < 0) d += 64;
        if (fl.br_pred_wrong) m_head = m_tail - d;
        else                  m_head = m_head + n_pop;
        for (int s = 0; s < 2; s++) begin
            if (fl.rob_retireEn[s]) begin
                m_log.push_back(int'(fl.rob_retireTagOld[s]));
                m_tail++;
            end
        end
    endtask

    task automatic set_idle();
        fl.de_destidx       = '0;
        fl.haz_nDispatched  = 2'd0;
        fl.rob_retireEn     = 2'b00;
        fl.rob_retireTagOld = '0;
        fl.br_pred_wrong    = 1'b0;
        fl.bs_recov_head    = '0;
    endtask

    task automatic drive(input logic [4:0] d0, input logic [4:0] d1, input int nd,
                         input logic [1:0] ren, input logic [5:0] t0, input logic [5:0] t1,
                         input logic bpw, input logic [5:0] rh);
        fl.de_destidx[0]       = d0;
        fl.de_destidx[1]       = d1;
        fl.haz_nDispatched     = 2'(nd);
        fl.rob_retireEn        = ren;
        fl.rob_retireTagOld[0] = t0;
        fl.rob_retireTagOld[1] = t1;
        fl.br_pred_wrong       = bpw;
        fl.bs_recov_head       = rh;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        set_idle();
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        set_idle();
        m_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (fl.fl_numFree !== 6'd32) begin
                n_err++; $display("FAIL reset_numfree c%0d: got %0d expected 32", c, fl.fl_numFree);
            end
            n_cmp++;
            if (fl.fl_head !== 6'd0) begin
                n_err++; $display("FAIL reset_head c%0d: got %0d expected 0", c, fl.fl_head);
            end
            drive(5'd1, 5'd2, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
            n_cmp++;
            if (fl.fl_freeRegs[0] !== 6'd32 || fl.fl_freeRegs[1] !== 6'd33) begin
                n_err++; $display("FAIL reset_freeregs c%0d: got {%0d,%0d} expected {33,32}",
                                  c, fl.fl_freeRegs[1], fl.fl_freeRegs[0]);
            end
            set_idle();
            tick();
        end
    endtask

    task automatic test_two_wide();
        do_reset();
        drive(5'd3, 5'd5, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
        n_cmp++;
        if (fl.fl_freeRegs[0] !== 6'd32 || fl.fl_freeRegs[1] !== 6'd33) begin
            n_err++; $display("FAIL two_wide_alloc: got {%0d,%0d} expected {33,32}",
                              fl.fl_freeRegs[1], fl.fl_freeRegs[0]);
        end
        tick();
        n_cmp++;
        if (fl.fl_numFree !== 6'd30 || fl.fl_head !== 6'd2) begin
            n_err++; $display("FAIL two_wide_state: got numFree %0d head %0d expected 30 2",
                              fl.fl_numFree, fl.fl_head);
        end
        drive(5'd1, 5'd2, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
        n_cmp++;
        if (fl.fl_freeRegs[0] !== 6'd34 || fl.fl_freeRegs[1] !== 6'd35) begin
            n_err++; $display("FAIL two_wide_next: got {%0d,%0d} expected {35,34}",
                              fl.fl_freeRegs[1], fl.fl_freeRegs[0]);
        end
        set_idle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(5'd31, 5'd4, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
        n_cmp++;
        if (fl.fl_freeRegs[1] !== 6'd32) begin
            n_err++; $display("FAIL zero_reg_slot1: got %0d expected 32", fl.fl_freeRegs[1]);
        end
        tick();
        n_cmp++;
        if (fl.fl_head !== 6'd1 || fl.fl_freeRegs[0] !== 6'd33 || fl.fl_numFree !== 6'd31) begin
            n_err++; $display("FAIL zero_reg_next: got head %0d free0 %0d numFree %0d expected 1 33 31",
                              fl.fl_head, fl.fl_freeRegs[0], fl.fl_numFree);
        end
    endtask

    task automatic test_compacted_retire();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(5'd1, 5'd2, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
            n_cmp++;
            if (fl.fl_freeRegs[0] !== 6'(32 + 2*i) || fl.fl_freeRegs[1] !== 6'(33 + 2*i)) begin
                n_err++; $display("FAIL drain_%0d: got {%0d,%0d} expected {%0d,%0d}", i,
                                  fl.fl_freeRegs[1], fl.fl_freeRegs[0], 33 + 2*i, 32 + 2*i);
            end
            tick();
        end
        n_cmp++;
        if (fl.fl_numFree !== 6'd0 || fl.fl_head !== 6'd32) begin
            n_err++; $display("FAIL drain_empty: got numFree %0d head %0d expected 0 32",
                              fl.fl_numFree, fl.fl_head);
        end
        drive(5'd0, 5'd0, 0, 2'b10, 6'd9, 6'd7, 1'b0, 6'd0);
        tick();
        n_cmp++;
        if (fl.fl_numFree !== 6'd1 || fl.fl_freeRegs[0] !== 6'd7) begin
            n_err++; $display("FAIL compact_slot1: got numFree %0d free0 %0d expected 1 7",
                              fl.fl_numFree, fl.fl_freeRegs[0]);
        end
    endtask

    task automatic test_mispredict();
        logic [5:0] snap;
        do_reset();
        drive(5'd1, 5'd2, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
        tick();
        snap = 6'(m_hptr());
        for (int i = 0; i < 2; i++) begin
            drive(5'd1, 5'd2, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
            tick();
        end
        n_cmp++;
        if (fl.fl_head !== 6'd6 || fl.fl_numFree !== 6'd26) begin
            n_err++; $display("FAIL mispred_pre: got head %0d numFree %0d expected 6 26",
                              fl.fl_head, fl.fl_numFree);
        end
        drive(5'd1, 5'd2, 2, 2'b11, 6'd32, 6'd33, 1'b1, snap);
        tick();
        n_cmp++;
        if (fl.fl_head !== 6'd2 || fl.fl_numFree !== 6'd32) begin
            n_err++; $display("FAIL mispred_post: got head %0d numFree %0d expected 2 32",
                              fl.fl_head, fl.fl_numFree);
        end
        n_cmp++;
        if (fl.fl_freeRegs[0] !== 6'd34) begin
            n_err++; $display("FAIL mispred_free0: got %0d expected 34", fl.fl_freeRegs[0]);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] p0, p1;
        do_reset();
        drive(5'd1, 5'd2, 2, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
        p0 = 6'(m_free(0));
        p1 = 6'(m_free(1));
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(5'd1, 5'd2, 2, 2'b11, p0, p1, 1'b0, 6'd0);
            n_cmp++;
            if (fl.fl_freeRegs[0] !== 6'(m_free(0)) || fl.fl_freeRegs[1] !== 6'(m_free(1))) begin
                n_err++; $display("FAIL wrap_order_%0d: got {%0d,%0d} expected {%0d,%0d}", i,
                                  fl.fl_freeRegs[1], fl.fl_freeRegs[0], m_free(1), m_free(0));
            end
            p0 = 6'(m_free(0));
            p1 = 6'(m_free(1));
            tick();
            n_cmp++;
            if (fl.fl_numFree !== 6'd30 || fl.fl_head !== 6'(m_hptr())) begin
                n_err++; $display("FAIL wrap_state_%0d: got numFree %0d head %0d expected 30 %0d",
                                  i, fl.fl_numFree, fl.fl_head, m_hptr());
            end
        end
    endtask

    task automatic test_random();
        int nf, nd, pops, npush, r, rmax;
        logic [4:0] d0, d1;
        logic [1:0] ren;
        logic bpw;
        logic [5:0] rh;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            nf = m_num();
            nd = int'($urandom % 3);
            d0 = ($urandom % 4 == 0) ? 5'd31 : 5'($urandom % 31);
            d1 = ($urandom % 4 == 0) ? 5'd31 : 5'($urandom % 31);
            pops = ((nd > 0 && d0 != 5'd31) ? 1 : 0) + ((nd > 1 && d1 != 5'd31) ? 1 : 0);
            if (pops > nf) nd = 0;
            ren = 2'($urandom % 4);
            npush = int'(ren[0]) + int'(ren[1]);
            if (nf + npush > 32) begin
                ren = 2'b00;
                npush = 0;
            end
            bpw = ($urandom % 16 == 0);
            rh = '0;
            if (bpw) begin
                rmax = 32 - nf - npush;
                r = int'($urandom_range(rmax, 0));
                rh = 6'((m_head - r) % 64);
            end
            drive(d0, d1, nd, ren, 6'($urandom), 6'($urandom), bpw, rh);
            n_cmp++;
            if (fl.fl_head !== 6'(m_hptr()) || fl.fl_numFree !== 6'(nf)) begin
                n_err++; $display("FAIL rand_state_%0d: got head %0d numFree %0d expected %0d %0d",
                                  c, fl.fl_head, fl.fl_numFree, m_hptr(), nf);
            end
            if (nf >= 1) begin
                n_cmp++;
                if (fl.fl_freeRegs[0] !== 6'(m_free(0))) begin
                    n_err++; $display("FAIL rand_free0_%0d: got %0d expected %0d",
                                      c, fl.fl_freeRegs[0], m_free(0));
                end
            end
            if (m_alloc(0) ? (nf >= 2) : (nf >= 1)) begin
                n_cmp++;
                if (fl.fl_freeRegs[1] !== 6'(m_free(1))) begin
                    n_err++; $display("FAIL rand_free1_%0d: got %0d expected %0d",
                                      c, fl.fl_freeRegs[1], m_free(1));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (fl.fl_numFree !== 6'd32 || fl.fl_head !== 6'd0 || fl.fl_freeRegs[0] !== 6'd32) begin
            n_err++; $display("FAIL mid_reset: got numFree %0d head %0d free0 %0d expected 32 0 32",
                              fl.fl_numFree, fl.fl_head, fl.fl_freeRegs[0]);
        end
        m_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tick();
        n_cmp++;
        if (fl.fl_numFree !== 6'd32 || fl.fl_head !== 6'd0) begin
            n_err++; $display("FAIL mid_reset_after: got numFree %0d head %0d expected 32 0",
                              fl.fl_numFree, fl.fl_head);
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_two_wide();
        test_zero_reg();
        test_compacted_retire();
        test_mispredict();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of unallocated physical register tags for the 2-way R10K core.
- Feeds `fl_freeRegs` to the map table and the reorder buffer at dispatch.
- Reclaims the old tags of retiring instructions from the ROB.
- On a branch mispredict, restores its head pointer from the branch stack snapshot, which makes every speculatively allocated tag free again.

Parameters:
- FL_SIZE, 32, number of free-list entries (NUM_PHYS - 32 architectural).
- PHYS_BITS, 6, width of a PHYS_REG tag.
- PTR_BITS, 6, pointer width: log2(FL_SIZE) index bits plus 1 wrap bit.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- de_destidx  in  2x5  architectural destination of dispatch slots 0/1; 5'd31 means no allocation.
- haz_nDispatched  in  2  number of slots dispatching this cycle (0..2, slot 0 first).
- rob_retireEn  in  2  per-slot retire-with-free strobe.
- rob_retireTagOld  in  2x6  tag freed by each retiring slot.
- br_pred_wrong  in  1  mispredict recovery this cycle.
- bs_recov_head  in  6  head pointer snapshot to restore.
- fl_freeRegs  out  2x6  tag allocated to slot 0 / slot 1.
- fl_head  out  6  current head pointer, snapshotted by the branch stack at branch dispatch.
- fl_numFree  out  6  occupancy 0..32, used by the hazard unit.

Behaviour:
- State:
  - entries[FL_SIZE] of PHYS_BITS each.
  - head and tail pointers, PTR_BITS each, with a wrap bit.
  - fl_numFree = tail - head, modulo 2^PTR_BITS.
- Reset (reset == 0, asynchronous):
  - entries[i] = 32 + i; head = 0; tail = 6'b100000.
  - Resulting outputs: fl_numFree = 32, fl_head = 0, fl_freeRegs = {33, 32}.
- Allocation steering (combinational):
  - fl_freeRegs[0] = entries[head].
  - fl_freeRegs[1] = entries[head+1] if slot 0 allocates, else entries[head].
  - Slot i allocates iff i < haz_nDispatched and de_destidx[i] != 31.
- Pop:
  - nPop = number of allocating slots (0..2).
  - head_next = head + nPop.
  - Pointer arithmetic wraps modulo 2^PTR_BITS; the index is ptr[PTR_BITS-2:0].
- Push:
  - Retiring tags are compacted: enabled slots write consecutively starting at tail, slot 0 first.
  - tail_next = tail + popcount(rob_retireEn).
  - If only slot 1 is enabled, its tag is written at tail.
- Latency:
  - A tag pushed in cycle N is visible on fl_freeRegs no earlier than cycle N+1.
  - There is no same-cycle push-to-pop bypass.
- Mispredict:
  - When br_pred_wrong = 1, head_next = bs_recov_head.
  - Dispatch pops in that cycle are discarded.
  - Retire pushes in the same cycle still apply: tail advances normally.
- Simultaneous push and pop in one cycle: both apply; fl_numFree_next = fl_numFree + nPush - nPop.
- Invariants, checked by assertion only (no RTL protection):
  - nPop <= fl_numFree; the hazard unit guarantees this.
  - fl_numFree + nPush <= FL_SIZE.
  - bs_recov_head lies within [head - FL_SIZE, tail], modulo wrap.
- Empty/full:
  - fl_numFree = 0: fl_freeRegs are don't-care and must not be consumed.
  - fl_numFree = 32: tail index equals head index and the wrap bits differ.
- Wrap-around: the slot 1 read at index FL_SIZE-1 takes index 0 for head+1.
- Reset asserted mid-operation restores the reset state immediately; there are no partial updates.

Test Plan:
- Reset release:
  - After reset goes high, fl_freeRegs = {33,32}, fl_numFree = 32, fl_head = 0.
  - Hold idle 3 cycles; all values stable.
- Two-wide dispatch:
  - haz_nDispatched = 2, destidx {3,5} for 1 cycle.
  - Next cycle: fl_freeRegs = {35,34}, fl_numFree = 30, fl_head = 2.
- Zero-reg steering:
  - From reset, destidx {31,4}, nDispatched = 2.
  - Same cycle: fl_freeRegs[1] = 32. Next cycle: fl_head = 1, fl_freeRegs[0] = 33.
- Compacted retire:
  - From reset, dispatch 2 per cycle for 16 cycles → fl_numFree = 0.
  - Then rob_retireEn = 2'b10 with tag 7 → next cycle fl_numFree = 1, fl_freeRegs[0] = 7.
- Mispredict with concurrent retire:
  - Snapshot fl_head = 2, then dispatch 4 more (head = 6).
  - Assert br_pred_wrong with bs_recov_head = 2, nDispatched = 2, and retire of 2 tags.
  - Next cycle: fl_head = 2, fl_numFree = 32.
- Wrap:
  - Run 20 cycles of 2-dispatch/2-retire with tags recycled.
  - Head and tail cross index 31 → 0; freeRegs order matches a reference FIFO model; fl_numFree stays constant.
